// File: rtl/param_commit_ctrl_pkg.sv
// Shared definitions for the parameter commit controller: FSM encoding and default bundle width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package param_commit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_SIZE = 128;

    // Last counter value before a forced commit; 0 when the timeout is disabled.
    function automatic int tmo_limit(input int timeout_cycles);
        return (timeout_cycles == 0) ? 0 : timeout_cycles - 1;
    endfunction

endpackage

// File: rtl/commit_timeout_counter.sv
// Counts busy cycles spent waiting for a commit slot and flags when the limit is reached.
// Latency: expired is combinational from the registered count and the enable.
// Backpressure: none; clr dominates en, and TIMEOUT_CYCLES=0 freezes the count and never expires.
module commit_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_WIDTH      = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [TMO_WIDTH-1:0] limit,
    output logic                 expired
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    logic [TMO_WIDTH-1:0] cnt;

    // Wait counter: restarts whenever the controller is outside WAIT, advances on busy cycles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && TMO_EN) begin
            cnt <= cnt + TMO_WIDTH'(1);
        end
    end

    assign expired = TMO_EN && en && (cnt == limit);

endmodule

// File: rtl/param_commit_ctrl.sv
// Shadows config-bank parameter writes and commits them atomically when the datapath is idle.
// Latency: param_en at edge E0 with dp_busy low gives params_load in the cycle after E1.
// Backpressure: dp_busy defers the commit; a timeout forces it and raises a sticky error.
module param_commit_ctrl
    import param_commit_ctrl_pkg::*;
#(
    parameter int DATA_SIZE      = DEFAULT_DATA_SIZE,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_WIDTH      = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [DATA_SIZE-1:0] regs_in,
    input  logic                 param_en,
    input  logic                 dp_busy,
    output logic [DATA_SIZE-1:0] params_out,
    output logic                 params_load,
    output logic                 dp_hold,
    output logic                 pending,
    output logic [CNT_WIDTH-1:0] commit_count,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int TMO_LIMIT = tmo_limit(TIMEOUT_CYCLES);

    state_t               state;
    logic [DATA_SIZE-1:0] shadow;
    logic                 tmo_expired;
    logic                 commit_now;

    commit_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_WIDTH      (TMO_WIDTH)
    ) u_tmo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (state != ST_WAIT),
        .en      ((state == ST_WAIT) && dp_busy),
        .limit   (TMO_WIDTH'(TMO_LIMIT)),
        .expired (tmo_expired)
    );

    // A commit happens in WAIT on the first idle datapath cycle, or when the wait times out.
    assign commit_now = (state == ST_WAIT) && (!dp_busy || tmo_expired);

    // Controller FSM with shadow capture, commit register, counter and sticky flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            shadow       <= '0;
            params_out   <= '0;
            params_load  <= 1'b0;
            commit_count <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (param_en) begin
                shadow <= regs_in;
            end
            params_load <= 1'b0;
            // Clear first so that a set later in this block wins on the same edge.
            if (err_clr) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (param_en) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (commit_now) begin
                        // A write on the commit edge bypasses the shadow so the newest value lands.
                        params_out   <= param_en ? regs_in : shadow;
                        params_load  <= 1'b1;
                        commit_count <= commit_count + CNT_WIDTH'(1);
                        state        <= ST_COMMIT;
                        if (tmo_expired) begin
                            timeout_err <= 1'b1;
                        end
                    end else if (param_en) begin
                        overrun <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= param_en ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dp_hold = (state == ST_WAIT);
    assign pending = (state == ST_WAIT);

endmodule
